// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: two independent glitch-free programmable clock dividers (write/read)
// sharing one ratio-update handshake; changes and stops land only on falling toggles.
module clk_div_ctrl #(
  parameter int CNT_W     = 16,
  parameter int W_DIV_RST = 12,
  parameter int R_DIV_RST = 20
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run_w,
  input  logic             run_r,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_done,
  output logic             w_clk,
  output logic             r_clk,
  output logic             w_active,
  output logic             r_active
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_st     [2];
  state_t           w_st_nx  [2];
  logic [CNT_W-1:0] r_cnt    [2];
  logic [CNT_W-1:0] r_div    [2];
  logic [CNT_W-1:0] w_cnt_nx [2];
  logic [CNT_W-1:0] w_h      [2];
  logic             r_ck     [2];
  logic             w_ck_nx  [2];
  logic             w_tog    [2];
  logic             w_apply  [2];
  logic             w_run    [2];
  logic             r_pend;
  logic             r_sel;
  logic             r_done;
  logic [CNT_W-1:0] r_div_new;

  always_comb begin
    w_run[0] = run_w;
    w_run[1] = run_r;
    for (int i = 0; i < 2; i++) begin
      w_h[i]     = (r_div[i] == '0) ? CNT_W'(1) : r_div[i];
      w_tog[i]   = (r_st[i] == RUN) && (r_cnt[i] == w_h[i] - CNT_W'(1));
      // a new ratio lands while stopped or at the end of a high phase, never mid-phase
      w_apply[i] = r_pend && (r_sel == 1'(i)) && ((r_st[i] == IDLE) || (w_tog[i] && r_ck[i]));
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_st_nx[i]  = (r_st[i] == IDLE) ? (w_run[i] ? RUN : IDLE)
                                      : ((w_tog[i] && r_ck[i] && !w_run[i]) ? IDLE : RUN);
      w_cnt_nx[i] = ((r_st[i] == IDLE) || w_tog[i]) ? '0 : r_cnt[i] + CNT_W'(1);
      w_ck_nx[i]  = (r_st[i] == RUN) && (w_tog[i] ? !r_ck[i] : r_ck[i]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_st[i]  <= IDLE;
        r_cnt[i] <= '0;
        r_ck[i]  <= 1'b0;
      end
      r_div[0]  <= CNT_W'(W_DIV_RST);
      r_div[1]  <= CNT_W'(R_DIV_RST);
      r_pend    <= 1'b0;
      r_sel     <= 1'b0;
      r_div_new <= '0;
      r_done    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_st[i]  <= w_st_nx[i];
        r_cnt[i] <= w_cnt_nx[i];
        r_ck[i]  <= w_ck_nx[i];
        if (w_apply[i]) r_div[i] <= r_div_new;
      end
      r_done <= w_apply[0] || w_apply[1];
      if (cfg_valid && !r_pend) begin
        r_pend    <= 1'b1;
        r_sel     <= cfg_sel;
        r_div_new <= cfg_div;
      end else if (w_apply[0] || w_apply[1]) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    w_clk     = r_ck[0];
    r_clk     = r_ck[1];
    w_active  = (r_st[0] == RUN);
    r_active  = (r_st[1] == RUN);
    cfg_ready = !r_pend;
    cfg_done  = r_done;
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: event scoreboard for clk_div_ctrl; a phase-scheduling reference model
// predicts every output change, and a monitor matches observed changes against it.
module tb_clk_div_ctrl;
  logic        clk_in = 0, rst_n = 0, run_w = 0, run_r = 0, cfg_valid = 0, cfg_sel = 0;
  logic [15:0] cfg_div = '0;
  logic        cfg_ready, cfg_done, w_clk, r_clk, w_active, r_active;
  int          tests = 0, fails = 0;

  typedef struct {int t; int k; int v;} ev_t;
  ev_t q[$];

  always #5 clk_in = ~clk_in;

  clk_div_ctrl dut (
    .clk_in(clk_in), .rst_n(rst_n), .run_w(run_w), .run_r(run_r),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
    .cfg_done(cfg_done), .w_clk(w_clk), .r_clk(r_clk), .w_active(w_active), .r_active(r_active)
  );

  function automatic int eff(int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Reference model: each running channel holds its level and the absolute cycle of its next toggle
  int t = 0;
  bit m_run[2], m_lvl[2], m_pend, m_psel, m_done;
  int m_nxt[2];
  int m_div[2] = '{12, 20};
  int m_pdiv;
  bit m_prev[6] = '{0, 0, 0, 0, 0, 1};

  always @(posedge clk_in or negedge rst_n) begin
    bit rin[2];
    bit ap[2];
    bit acc;
    bit s[6];
    if (!rst_n) begin
      m_run = '{0, 0};
      m_lvl = '{0, 0};
      m_div = '{12, 20};
      m_pend = 0;
      m_done = 0;
    end else begin
      t++;
      rin = '{run_w, run_r};
      acc = cfg_valid && !m_pend;
      for (int c = 0; c < 2; c++) begin
        ap[c] = 0;
        if (!m_run[c]) begin
          ap[c] = m_pend && (m_psel == c[0]);
          if (ap[c]) m_div[c] = m_pdiv;
          if (rin[c]) begin
            m_run[c] = 1;
            m_nxt[c] = t + eff(m_div[c]);
          end
        end else if (t == m_nxt[c]) begin
          if (m_lvl[c]) begin
            m_lvl[c] = 0;
            ap[c] = m_pend && (m_psel == c[0]);
            if (ap[c]) m_div[c] = m_pdiv;
            if (!rin[c]) m_run[c] = 0;
          end else begin
            m_lvl[c] = 1;
          end
          m_nxt[c] = t + eff(m_div[c]);
        end
      end
      m_done = ap[0] || ap[1];
      if (acc) begin
        m_pend = 1;
        m_psel = cfg_sel;
        m_pdiv = int'(cfg_div);
      end else if (m_done) begin
        m_pend = 0;
      end
      s = '{m_lvl[0], m_lvl[1], m_done, m_run[0], m_run[1], !m_pend};
      for (int k = 0; k < 6; k++)
        if (s[k] != m_prev[k] || (k == 2 && s[k])) q.push_back(ev_t'{t, k, int'(s[k])});
      m_prev = s;
    end
  end

  // Monitor: kinds 0 w_clk, 1 r_clk, 2 cfg_done pulse, 3 w_active, 4 r_active, 5 cfg_ready
  initial begin
    logic p[6] = '{0, 0, 0, 0, 0, 1};
    logic s[6];
    ev_t  e;
    forever begin
      @(posedge clk_in);
      if (!rst_n) continue;
      #1;
      s = '{w_clk, r_clk, cfg_done, w_active, r_active, cfg_ready};
      for (int k = 0; k < 6; k++) begin
        if (s[k] !== p[k] || (k == 2 && s[k] === 1'b1)) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL event: got kind=%0d t=%0d v=%0b, required no event", k, t, s[k]);
          end else begin
            e = q.pop_front();
            if (e.t != t || e.k != k || e.v !== int'(s[k])) begin
              fails++;
              $display("FAIL event: got kind=%0d t=%0d v=%0b, required kind=%0d t=%0d v=%0d",
                       k, t, s[k], e.k, e.t, e.v);
            end
          end
        end
      end
      p = s;
    end
  end

  task automatic chk(input string n, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0b, required %0b", n, a, e);
    end
  endtask

  task automatic chk_reset();
    chk("rst_w_clk", w_clk, 1'b0);
    chk("rst_r_clk", r_clk, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_w_active", w_active, 1'b0);
    chk("rst_r_active", r_active, 1'b0);
  endtask

  task automatic send_cfg(input logic s, input logic [15:0] d);
    bit ok = 0;
    cfg_sel   = s;
    cfg_div   = d;
    cfg_valid = 1;
    for (int k = 0; k < 500 && !ok; k++) begin
      if (cfg_ready) ok = 1;
      @(negedge clk_in);
    end
    cfg_valid = 0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL cfg_timeout: got cfg_ready=0 for 500 cycles, required 1");
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk_in);
    #3 rst_n = 0;
    #1 chk_reset();
    #2 rst_n = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    bit hit = 0;
    repeat (3) @(posedge clk_in);
    #1 chk_reset();
    @(negedge clk_in);
    rst_n = 1;
    idle(1);
    run_w = 1;
    run_r = 1;
    idle(100);
    send_cfg(0, 16'd3);
    idle(60);
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk_in);
      hit = r_clk;
    end
    idle(2);
    run_r = 0;
    idle(60);
    run_r = 1;
    idle(60);
    send_cfg(0, 16'd0);
    send_cfg(0, 16'd1);
    idle(20);
    run_r = 0;
    idle(60);
    send_cfg(1, 16'd7);
    idle(5);
    run_r = 1;
    idle(60);
    send_cfg(0, 16'd12);
    send_cfg(1, 16'd15);
    reset_pulse();
    idle(80);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_in);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_cfg(1'($urandom_range(0, 1)), 16'($urandom_range(0, 9)));
        4, 5:       run_w = 1'($urandom_range(0, 1));
        6, 7:       run_r = 1'($urandom_range(0, 1));
        8:          reset_pulse();
        default:    ;
      endcase
      idle($urandom_range(1, 30));
    end
    idle(100);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d unobserved events, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
